dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the core's load/store port (address, store data, write strobe, DMType).
- Accepts one request at a time through a valid/ready handshake and inserts a programmable number of wait states.
- Stores apply byte-lane merge; loads return data right-aligned and sign- or zero-extended per DMType.
- Sits between the pipeline's MEM stage and a word-organised storage array held inside the block.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side end of the core's load/store port: one request at a time, programmable
// wait states, byte-lane merged stores and sign/zero-extended loads from an internal array.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  input  logic [2:0]  DMType,
  output logic        rsp_valid,
  output logic [31:0] Data_out,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           memW_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    data_q;
  logic [2:0]     dmType_q;
  logic [31:0]    dataOut_q, dataOut_d;
  logic           misalign_q, misalign_d;
  logic [31:0]    mem_q [DEPTH_WORDS];

  logic           accept, commit;
  logic           curW, curMis;
  logic [AW+1:0]  curAddr;
  logic [31:0]    curData;
  logic [2:0]     curType;
  logic [AW-1:0]  idx;
  logic [31:0]    rdWord, wrData, ldData;
  logic [15:0]    halfSel;
  logic [7:0]     byteSel;
  logic [3:0]     wrBe;
  logic           unusedAddr;

  assign unusedAddr = ^Addr_in[31:AW+2];
  assign accept     = (state_q == S_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dataOut_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dataOut_q  <= dataOut_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      memW_q   <= mem_w;
      addr_q   <= Addr_in[AW+1:0];
      data_q   <= Data_in;
      dmType_q <= DMType;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        cnt_d   = WAIT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit lands on the accept edge, so use the live inputs then.
  always_comb begin
    curW    = memW_q;
    curAddr = addr_q;
    curData = data_q;
    curType = dmType_q;
    if (state_q == S_IDLE) begin
      curW    = mem_w;
      curAddr = Addr_in[AW+1:0];
      curData = Data_in;
      curType = DMType;
    end
  end

  assign commit = (state_d == S_RESP) && (state_q != S_RESP);
  assign idx    = curAddr[AW+1:2];

  always_comb begin
    curMis = 1'b1;
    wrData = '0;
    wrBe   = 4'b0000;
    case (curType)
      3'b000: begin
        curMis = (curAddr[1:0] != 2'b00);
        wrData = curData;
        wrBe   = 4'b1111;
      end
      3'b001, 3'b010: begin
        curMis = curAddr[0];
        wrData = {2{curData[15:0]}};
        wrBe   = curAddr[1] ? 4'b1100 : 4'b0011;
      end
      3'b011, 3'b100: begin
        curMis = 1'b0;
        wrData = {4{curData[7:0]}};
        wrBe   = 4'b0001 << curAddr[1:0];
      end
      default: curMis = 1'b1;
    endcase
  end

  always_comb begin
    rdWord  = mem_q[idx];
    halfSel = curAddr[1] ? rdWord[31:16] : rdWord[15:0];
    byteSel = rdWord[8*curAddr[1:0] +: 8];
    ldData  = '0;
    case (curType)
      3'b000:  ldData = rdWord;
      3'b001:  ldData = {{16{halfSel[15]}}, halfSel};
      3'b010:  ldData = {16'h0000, halfSel};
      3'b011:  ldData = {{24{byteSel[7]}}, byteSel};
      3'b100:  ldData = {24'h000000, byteSel};
      default: ldData = '0;
    endcase
    dataOut_d  = (commit && !curMis && !curW) ? ldData : '0;
    misalign_d = commit && curMis;
  end

  // Reset on the commit edge suppresses the write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!reset && commit && curW && !curMis) begin
      for (int k = 0; k < 4; k++) begin
        if (wrBe[k]) mem_q[idx][8*k +: 8] <= wrData[8*k +: 8];
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign Data_out     = dataOut_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (1, 0 and 3 wait states) driven by a directed
// vector table plus hand-written sequences for back-to-back accepts and mid-flight reset.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       reqValid;
  logic [2:0]       reqReady;
  logic [2:0]       memW;
  logic [2:0][31:0] addrIn;
  logic [2:0][31:0] dataIn;
  logic [2:0][2:0]  dmType;
  logic [2:0]       rspValid;
  logic [2:0][31:0] dataOut;
  logic [2:0]       misErr;

  int nChecks = 0;
  int nFails  = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dutW1 (
    .clk(clk), .reset(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .mem_w(memW[0]), .Addr_in(addrIn[0]), .Data_in(dataIn[0]), .DMType(dmType[0]),
    .rsp_valid(rspValid[0]), .Data_out(dataOut[0]), .misalign_err(misErr[0]));

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dutW0 (
    .clk(clk), .reset(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .mem_w(memW[1]), .Addr_in(addrIn[1]), .Data_in(dataIn[1]), .DMType(dmType[1]),
    .rsp_valid(rspValid[1]), .Data_out(dataOut[1]), .misalign_err(misErr[1]));

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dutW3 (
    .clk(clk), .reset(rst[2]), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
    .mem_w(memW[2]), .Addr_in(addrIn[2]), .Data_in(dataIn[2]), .DMType(dmType[2]),
    .rsp_valid(rspValid[2]), .Data_out(dataOut[2]), .misalign_err(misErr[2]));

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  t;
    logic [31:0] expD;
    logic        expE;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // After the accept edge the request inputs are scrambled to prove they were latched.
  task automatic applyStimulus(input int i, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] t,
                               output logic [31:0] rd, output logic re, output int lat);
    @(negedge clk);
    memW[i] = w; addrIn[i] = a; dataIn[i] = d; dmType[i] = t; reqValid[i] = 1'b1;
    @(posedge clk);
    #1;
    reqValid[i] = 1'b0; memW[i] = ~w; addrIn[i] = a ^ 32'h4; dataIn[i] = ~d; dmType[i] = 3'b111;
    lat = -1; rd = '0; re = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rspValid[i]) begin
        lat = c; rd = dataOut[i]; re = misErr[i];
        break;
      end
    end
  endtask

  task automatic resetMidFlight(input int i, input logic [31:0] a, input logic [31:0] d,
                                input int k, input string tag);
    int seen;
    seen = 0;
    @(negedge clk);
    memW[i] = 1'b1; addrIn[i] = a; dataIn[i] = d; dmType[i] = 3'b000; reqValid[i] = 1'b1;
    @(posedge clk);
    #1;
    reqValid[i] = 1'b0;
    repeat (k - 1) @(posedge clk);
    @(negedge clk);
    if (rspValid[i]) seen++;
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
    checkOutput({tag, " ready after reset"}, 32'(reqReady[i]), 32'd1);
    checkOutput({tag, " rsp after reset"}, 32'(rspValid[i]), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rspValid[i]) seen++;
    end
    checkOutput({tag, " no response"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat;

    rst = 3'b111; reqValid = '0; memW = '0; addrIn = '0; dataIn = '0; dmType = '0;

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF, 3'b000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b000, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0010, 32'h11223344, 3'b000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0013, 32'h0000_0080, 3'b011, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0000_0000, 3'b011, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0013, 32'h0000_0000, 3'b100, 32'h0000_0080, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b000, 32'h80223344, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0011, 32'hFFFFFF7F, 3'b100, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 3'b000, 32'h80227F44, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h01020304, 3'b000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0022, 32'h1234A5A5, 3'b001, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0022, 32'h0000_0000, 3'b001, 32'hFFFFA5A5, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0022, 32'h0000_0000, 3'b010, 32'h0000A5A5, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0021, 32'hFFFFFFFF, 3'b000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 3'b000, 32'hA5A50304, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 3'b111, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0023, 32'h0000BBBB, 3'b001, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0021, 32'h0000_0000, 3'b010, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 3'b011, 32'h0000_0004, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 3'b001, 32'h0000_0304, 1'b0});
    vecs.push_back('{1'b1, 32'h1000_0004, 32'h12345678, 3'b000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0000_0000, 3'b000, 32'h12345678, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d ready", i), 32'(reqReady[i]), 32'd1);
      checkOutput($sformatf("reset%0d rsp", i), 32'(rspValid[i]), 32'd0);
      checkOutput($sformatf("reset%0d data", i), dataOut[i], 32'd0);
      checkOutput($sformatf("reset%0d err", i), 32'(misErr[i]), 32'd0);
    end
    rst = 3'b000;

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(0, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].t, rd, re, lat);
      checkOutput($sformatf("vec%0d latency", k), 32'(lat), 32'd2);
      checkOutput($sformatf("vec%0d data", k), rd, vecs[k].expD);
      checkOutput($sformatf("vec%0d err", k), 32'(re), 32'(vecs[k].expE));
    end

    // Zero wait states with req_valid held: an accept every other cycle.
    @(negedge clk);
    memW[1] = 1'b1; addrIn[1] = 32'h0; dataIn[1] = 32'h5A5A1234; dmType[1] = 3'b000;
    reqValid[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      checkOutput($sformatf("ws0 ready c%0d", j), 32'(reqReady[1]), (j % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ws0 rsp c%0d", j), 32'(rspValid[1]), (j % 2 == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    checkOutput("ws0 ready c4", 32'(reqReady[1]), 32'd1);
    memW[1] = 1'b0;
    @(negedge clk);
    checkOutput("ws0 load rsp", 32'(rspValid[1]), 32'd1);
    checkOutput("ws0 load data", dataOut[1], 32'h5A5A1234);
    reqValid[1] = 1'b0;
    applyStimulus(1, 1'b0, 32'h1, 32'h0, 3'b100, rd, re, lat);
    checkOutput("ws0 lbu latency", 32'(lat), 32'd1);
    checkOutput("ws0 lbu data", rd, 32'h0000_0012);

    // Three wait states: reset during WAIT and on the RESP-entry edge must drop the store.
    applyStimulus(2, 1'b1, 32'h8, 32'h0BADCAFE, 3'b000, rd, re, lat);
    checkOutput("ws3 store latency", 32'(lat), 32'd4);
    applyStimulus(2, 1'b1, 32'hC, 32'h13579BDF, 3'b000, rd, re, lat);
    checkOutput("ws3 store2 latency", 32'(lat), 32'd4);
    resetMidFlight(2, 32'h8, 32'hCAFEF00D, 2, "ws3 wait2");
    applyStimulus(2, 1'b0, 32'h8, 32'h0, 3'b000, rd, re, lat);
    checkOutput("ws3 reload latency", 32'(lat), 32'd4);
    checkOutput("ws3 reload data", rd, 32'h0BADCAFE);
    checkOutput("ws3 reload err", 32'(re), 32'd0);
    resetMidFlight(2, 32'hC, 32'hFFFF0000, 3, "ws3 respedge");
    applyStimulus(2, 1'b0, 32'hC, 32'h0, 3'b000, rd, re, lat);
    checkOutput("ws3 reload2 data", rd, 32'h13579BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
